// File: rtl/ov7670_capture_ds.sv
// OV7670 pixel capture: synchronises the camera bus into clk, packs byte pairs into
// 16-bit pixels, decimates by 2^C_DEC_LOG2 in both axes and emits frame-buffer writes.
module ov7670_capture_ds #(
  parameter int C_IMG_COLS = 320,
  parameter int C_IMG_ROWS = 240,
  parameter int C_DEC_LOG2 = 0,
  parameter int C_NB_ADDR  = 17,
  parameter int C_VS_FILT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pclk,
  input  logic                 href,
  input  logic                 vsync,
  input  logic [7:0]           data,
  input  logic [1:0]           mode,
  input  logic                 swap_r_b,
  input  logic                 arm,
  input  logic                 single,
  output logic [C_NB_ADDR-1:0] addr,
  output logic [15:0]          dout,
  output logic                 we,
  output logic                 frame_done,
  output logic                 busy,
  output logic [7:0]           frame_cnt,
  output logic                 err_long
);

  localparam int          OUT_COLS = C_IMG_COLS >> C_DEC_LOG2;
  localparam logic [15:0] DEC_MASK = 16'((1 << C_DEC_LOG2) - 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_ACTIVE, S_DONE} state_t;

  state_t               state_q, state_d;
  logic                 hold_q, hold_d;
  logic [2:0]           pclk_sr_q, href_sr_q, vsync_sr_q;
  logic [7:0]           data_rg1_q, data_rg2_q, data_rg3_q;
  logic                 href_p_q;
  logic [3:0]           vs_cnt_q, vs_cnt_d;
  logic                 vs_f_q, vs_f_d, vs_fp_q;
  logic                 byte_q, byte_d;
  logic [7:0]           b0_q, b0_d;
  logic [15:0]          col_q, col_d, row_q, row_d;
  logic [C_NB_ADDR-1:0] base_q, base_d, addr_q, addr_d;
  logic [15:0]          dout_q, dout_d, pix;
  logic                 we_q, we_d, err_q, err_d;
  logic [7:0]           fcnt_q;

  logic pclk_rise, href_s, href_fall, vsync_s, vs_rise, vs_fall;
  logic start_sync, enter_active, px_keep, row_keep;

  assign pclk_rise = pclk_sr_q[1] & ~pclk_sr_q[2];
  assign href_s    = href_sr_q[2];
  assign vsync_s   = vsync_sr_q[2];
  assign href_fall = href_p_q & ~href_s;
  assign vs_rise   = vs_f_q & ~vs_fp_q;
  assign vs_fall   = ~vs_f_q & vs_fp_q;

  // A single-frame capture parks in IDLE until arm is dropped, so it cannot re-trigger.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q & arm;
    case (state_q)
      S_IDLE:   if (arm && !hold_q) state_d = S_SYNC;
      S_SYNC:   if (vs_fall) state_d = S_ACTIVE;
      S_ACTIVE: if (vs_rise) state_d = S_DONE;
      S_DONE: begin
        if (arm && !single) begin
          state_d = S_SYNC;
        end else begin
          state_d = S_IDLE;
          hold_d  = arm;
        end
      end
      default:  state_d = S_IDLE;
    endcase
    if (!arm) state_d = S_IDLE;
  end

  assign start_sync   = (state_q == S_IDLE) && (state_d == S_SYNC);
  assign enter_active = (state_q == S_SYNC) && (state_d == S_ACTIVE);
  assign px_keep      = ((col_q & DEC_MASK) == 16'd0) && ((row_q & DEC_MASK) == 16'd0);
  assign row_keep     = (row_q & DEC_MASK) == 16'd0;

  always_comb begin
    vs_cnt_d = vs_cnt_q;
    vs_f_d   = vs_f_q;
    if (!vsync_s) begin
      vs_cnt_d = 4'd0;
      vs_f_d   = 1'b0;
    end else begin
      if (vs_cnt_q < 4'(C_VS_FILT)) vs_cnt_d = vs_cnt_q + 4'd1;
      if (vs_cnt_q >= 4'(C_VS_FILT - 1)) vs_f_d = 1'b1;
    end
  end

  // Swapping exchanges the outermost colour fields; gray has no colour to swap.
  always_comb begin
    pix = {8'h00, b0_q};
    if (!mode[1]) begin
      if (mode[0]) begin
        pix = swap_r_b ? {data_rg3_q[4:0], b0_q[2:0], data_rg3_q[7:5], b0_q[7:3]}
                       : {b0_q, data_rg3_q};
      end else begin
        pix = swap_r_b ? {4'h0, data_rg3_q[3:0], data_rg3_q[7:4], b0_q[3:0]}
                       : {4'h0, b0_q[3:0], data_rg3_q[7:4], data_rg3_q[3:0]};
      end
    end
  end

  always_comb begin
    byte_d = byte_q;
    b0_d   = b0_q;
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    addr_d = addr_q;
    dout_d = dout_q;
    we_d   = 1'b0;
    err_d  = err_q;
    if (start_sync) err_d = 1'b0;
    if (enter_active) begin
      byte_d = 1'b0;
      col_d  = 16'd0;
      row_d  = 16'd0;
      base_d = '0;
    end else if (state_q == S_ACTIVE) begin
      if (!href_s) begin
        byte_d = 1'b0;
      end else if (pclk_rise) begin
        if (!byte_q) begin
          b0_d   = data_rg3_q;
          byte_d = 1'b1;
        end else begin
          byte_d = 1'b0;
          if (col_q != 16'hFFFF) col_d = col_q + 16'd1;
          if (col_q >= 16'(C_IMG_COLS) || row_q >= 16'(C_IMG_ROWS)) begin
            err_d = 1'b1;
          end else if (px_keep) begin
            we_d   = 1'b1;
            addr_d = base_q + C_NB_ADDR'(col_q >> C_DEC_LOG2);
            dout_d = pix;
          end
        end
      end
      // Row base steps by a nominal line, so short lines never shift later rows.
      if (href_fall) begin
        col_d = 16'd0;
        if (row_q != 16'hFFFF) row_d = row_q + 16'd1;
        if (row_keep) base_d = base_q + C_NB_ADDR'(OUT_COLS);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_q     <= 1'b0;
      pclk_sr_q  <= 3'd0;
      href_sr_q  <= 3'd0;
      vsync_sr_q <= 3'd0;
      data_rg1_q <= 8'd0;
      data_rg2_q <= 8'd0;
      data_rg3_q <= 8'd0;
      href_p_q   <= 1'b0;
      vs_cnt_q   <= 4'd0;
      vs_f_q     <= 1'b0;
      vs_fp_q    <= 1'b0;
      byte_q     <= 1'b0;
      b0_q       <= 8'd0;
      col_q      <= 16'd0;
      row_q      <= 16'd0;
      base_q     <= '0;
      addr_q     <= '0;
      dout_q     <= 16'd0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      fcnt_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      pclk_sr_q  <= {pclk_sr_q[1:0], pclk};
      href_sr_q  <= {href_sr_q[1:0], href};
      vsync_sr_q <= {vsync_sr_q[1:0], vsync};
      data_rg1_q <= data;
      data_rg2_q <= data_rg1_q;
      data_rg3_q <= data_rg2_q;
      href_p_q   <= href_s;
      vs_cnt_q   <= vs_cnt_d;
      vs_f_q     <= vs_f_d;
      vs_fp_q    <= vs_f_q;
      byte_q     <= byte_d;
      b0_q       <= b0_d;
      col_q      <= col_d;
      row_q      <= row_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      we_q       <= we_d;
      err_q      <= err_d;
      if (state_q == S_DONE) fcnt_q <= fcnt_q + 8'd1;
    end
  end

  assign addr       = addr_q;
  assign dout       = dout_q;
  assign we         = we_q;
  assign frame_done = (state_q == S_DONE);
  assign busy       = (state_q == S_ACTIVE);
  assign frame_cnt  = fcnt_q;
  assign err_long   = err_q;

endmodule

// File: tb/tb_ov7670_capture_ds.sv
// Directed bench for ov7670_capture_ds: a 4x3 full-resolution instance and an 8x4
// instance decimated by 2, both fed from one emulated camera bus.
module tb_ov7670_capture_ds;

  typedef struct {
    logic [1:0]  mode;
    logic        swap;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] expDout;
  } vec_t;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pclk = 1'b0, href = 1'b0, vsync = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] mode = 2'b01;
  logic       swapRB = 1'b0, armA = 1'b0, armB = 1'b0, single = 1'b0;

  logic [7:0]  addrA, addrB, fcntA, fcntB;
  logic [15:0] doutA, doutB;
  logic        weA, weB, fdoneA, fdoneB, busyA, busyB, errA, errB;

  wr_t wrA[$];
  wr_t wrB[$];
  int  fdA = 0, fdB = 0;
  int  nChecks = 0, nFail = 0;

  always #5 clk = ~clk;

  ov7670_capture_ds #(.C_IMG_COLS(4), .C_IMG_ROWS(3), .C_DEC_LOG2(0), .C_NB_ADDR(8), .C_VS_FILT(4)) u_dut (
    .clk(clk), .rst(rst), .pclk(pclk), .href(href), .vsync(vsync), .data(data),
    .mode(mode), .swap_r_b(swapRB), .arm(armA), .single(single),
    .addr(addrA), .dout(doutA), .we(weA), .frame_done(fdoneA), .busy(busyA),
    .frame_cnt(fcntA), .err_long(errA));

  ov7670_capture_ds #(.C_IMG_COLS(8), .C_IMG_ROWS(4), .C_DEC_LOG2(1), .C_NB_ADDR(8), .C_VS_FILT(4)) u_dec (
    .clk(clk), .rst(rst), .pclk(pclk), .href(href), .vsync(vsync), .data(data),
    .mode(mode), .swap_r_b(swapRB), .arm(armB), .single(single),
    .addr(addrB), .dout(doutB), .we(weB), .frame_done(fdoneB), .busy(busyB),
    .frame_cnt(fcntB), .err_long(errB));

  // Records every write strobe and frame_done pulse mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (weA) wrA.push_back({addrA, doutA});
    if (weB) wrB.push_back({addrB, doutB});
    if (fdoneA) fdA++;
    if (fdoneB) fdB++;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic checkWrite(input bit useB, input int idx, input logic [7:0] a,
                            input logic [15:0] d, input string name);
    wr_t w;
    int  n;
    n = useB ? wrB.size() : wrA.size();
    nChecks++;
    if (idx >= n) begin
      nFail++;
      $display("[TB] FAIL %s: write %0d missing (only %0d seen), expected addr 0x%0h dout 0x%0h",
               name, idx, n, a, d);
    end else begin
      w = useB ? wrB[idx] : wrA[idx];
      if (w.a !== a || w.d !== d) begin
        nFail++;
        $display("[TB] FAIL %s: write %0d got addr 0x%0h dout 0x%0h expected addr 0x%0h dout 0x%0h",
                 name, idx, w.a, w.d, a, d);
      end
    end
  endtask

  // Data changes while pclk is low so it is settled well before the rising edge.
  task automatic sendByte(input logic [7:0] b);
    data = b;
    pclk = 1'b0;
    #40;
    pclk = 1'b1;
    #40;
  endtask

  task automatic sendLine(input int nPix, input int row, input logic [7:0] b0,
                          input logic [7:0] b1, input bit useIdx);
    href = 1'b1;
    #40;
    for (int p = 0; p < nPix; p++) begin
      if (useIdx) begin
        sendByte(8'(row));
        sendByte(8'(p));
      end else begin
        sendByte(b0);
        sendByte(b1);
      end
    end
    pclk = 1'b0;
    #40;
    href = 1'b0;
    #120;
  endtask

  task automatic sendVsync(input int cycles);
    vsync = 1'b1;
    #(10 * cycles);
    vsync = 1'b0;
    #100;
  endtask

  task automatic sendFrame(input logic [7:0] b0, input logic [7:0] b1, input bit useIdx);
    for (int r = 0; r < 3; r++) sendLine(4, r, b0, b1, useIdx);
  endtask

  // One table vector is one complete frame followed by the closing vsync.
  task automatic applyStimulus(input vec_t v);
    mode   = v.mode;
    swapRB = v.swap;
    sendFrame(v.b0, v.b1, 1'b0);
    sendVsync(8);
  endtask

  vec_t vecs[7];
  int   mW, mF;

  initial begin
    vecs[0] = '{2'b01, 1'b0, 8'hF8, 8'h1F, 16'hF81F};
    vecs[1] = '{2'b01, 1'b1, 8'hF8, 8'h00, 16'h001F};
    vecs[2] = '{2'b01, 1'b1, 8'h12, 8'h34, 16'hA222};
    vecs[3] = '{2'b00, 1'b0, 8'h0A, 8'hBC, 16'h0ABC};
    vecs[4] = '{2'b00, 1'b1, 8'h0A, 8'hBC, 16'h0CBA};
    vecs[5] = '{2'b10, 1'b1, 8'h5A, 8'h77, 16'h005A};
    vecs[6] = '{2'b11, 1'b0, 8'hC3, 8'h00, 16'h00C3};

    #25;
    checkOutput("reset addr", 32'(addrA), 32'h0);
    checkOutput("reset dout", 32'(doutA), 32'h0);
    checkOutput("reset we", 32'(weA), 32'h0);
    checkOutput("reset frame_done", 32'(fdoneA), 32'h0);
    checkOutput("reset busy", 32'(busyA), 32'h0);
    checkOutput("reset frame_cnt", 32'(fcntA), 32'h0);
    checkOutput("reset err_long", 32'(errA), 32'h0);
    checkOutput("reset dec busy", 32'(busyB), 32'h0);
    rst = 1'b0;
    #20;

    $display("[TB] pixel packing vectors on 4x3 frames");
    armA = 1'b1;
    #30;
    sendVsync(8);
    for (int i = 0; i < 7; i++) begin
      mW = wrA.size();
      mF = fdA;
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d write count", i), 32'(wrA.size() - mW), 32'd12);
      for (int k = 0; k < 12; k++)
        checkWrite(1'b0, mW + k, 8'(k), vecs[i].expDout, $sformatf("vec%0d pixel", i));
      checkOutput($sformatf("vec%0d frame_done", i), 32'(fdA - mF), 32'd1);
      checkOutput($sformatf("vec%0d frame_cnt", i), 32'(fcntA), 32'(i + 1));
    end
    checkOutput("active busy", 32'(busyA), 32'h1);
    armA = 1'b0;
    #30;
    checkOutput("disarm busy", 32'(busyA), 32'h0);

    $display("[TB] decimation by 2 on an 8x4 frame");
    mode   = 2'b01;
    swapRB = 1'b0;
    armB   = 1'b1;
    #30;
    sendVsync(8);
    mW = wrB.size();
    mF = fdB;
    for (int r = 0; r < 4; r++) sendLine(8, r, 8'h00, 8'h00, 1'b1);
    sendVsync(8);
    checkOutput("dec write count", 32'(wrB.size() - mW), 32'd8);
    for (int k = 0; k < 8; k++)
      checkWrite(1'b1, mW + k, 8'(k), {8'((k / 4) * 2), 8'((k % 4) * 2)}, "dec pixel");
    checkOutput("dec frame_done", 32'(fdB - mF), 32'd1);
    checkOutput("dec frame_cnt", 32'(fcntB), 32'd1);
    armB = 1'b0;
    #30;

    $display("[TB] long and short lines");
    armA = 1'b1;
    #30;
    checkOutput("err clear before long", 32'(errA), 32'h0);
    sendVsync(8);
    mW = wrA.size();
    sendLine(6, 0, 8'h00, 8'h00, 1'b1);
    checkOutput("err after long line", 32'(errA), 32'h1);
    sendLine(2, 1, 8'h00, 8'h00, 1'b1);
    sendLine(4, 2, 8'h00, 8'h00, 1'b1);
    sendVsync(8);
    checkOutput("long write count", 32'(wrA.size() - mW), 32'd10);
    for (int k = 0; k < 4; k++) checkWrite(1'b0, mW + k, 8'(k), {8'h00, 8'(k)}, "long row0");
    for (int k = 0; k < 2; k++) checkWrite(1'b0, mW + 4 + k, 8'(4 + k), {8'h01, 8'(k)}, "short row1");
    for (int k = 0; k < 4; k++) checkWrite(1'b0, mW + 6 + k, 8'(8 + k), {8'h02, 8'(k)}, "row2 base");
    armA = 1'b0;
    #30;
    checkOutput("err sticky in idle", 32'(errA), 32'h1);
    armA = 1'b1;
    #30;
    checkOutput("err cleared on sync", 32'(errA), 32'h0);

    $display("[TB] vsync glitch filtering");
    sendVsync(8);
    mW = wrA.size();
    mF = fdA;
    sendLine(4, 0, 8'h00, 8'h00, 1'b1);
    vsync = 1'b1; #10; vsync = 1'b0; #80;
    sendLine(4, 1, 8'h00, 8'h00, 1'b1);
    vsync = 1'b1; #30; vsync = 1'b0; #80;
    sendLine(4, 2, 8'h00, 8'h00, 1'b1);
    checkOutput("glitch no frame_done", 32'(fdA - mF), 32'd0);
    checkOutput("glitch still busy", 32'(busyA), 32'h1);
    vsync = 1'b1; #40; vsync = 1'b0; #100;
    checkOutput("glitch frame_done", 32'(fdA - mF), 32'd1);
    checkOutput("glitch write count", 32'(wrA.size() - mW), 32'd12);
    for (int k = 0; k < 12; k++)
      checkWrite(1'b0, mW + k, 8'(k), {8'(k / 4), 8'(k % 4)}, "glitch pixel");

    $display("[TB] single-frame capture");
    armA = 1'b0;
    single = 1'b1;
    #30;
    armA = 1'b1;
    #30;
    mW = wrA.size();
    mF = fdA;
    sendVsync(8);
    sendFrame(8'h00, 8'h00, 1'b1);
    sendVsync(8);
    sendFrame(8'h00, 8'h00, 1'b1);
    sendVsync(8);
    checkOutput("single frame_done", 32'(fdA - mF), 32'd1);
    checkOutput("single write count", 32'(wrA.size() - mW), 32'd12);
    checkOutput("single busy after", 32'(busyA), 32'h0);
    armA = 1'b0;
    single = 1'b0;
    #30;

    $display("[TB] reset in mid-frame");
    armA = 1'b1;
    #30;
    sendVsync(8);
    sendLine(4, 0, 8'h00, 8'h00, 1'b1);
    rst = 1'b1;
    #20;
    checkOutput("midreset busy", 32'(busyA), 32'h0);
    checkOutput("midreset frame_cnt", 32'(fcntA), 32'h0);
    rst = 1'b0;
    mW = wrA.size();
    mF = fdA;
    sendLine(4, 1, 8'h00, 8'h00, 1'b1);
    sendLine(4, 2, 8'h00, 8'h00, 1'b1);
    checkOutput("midreset no writes", 32'(wrA.size() - mW), 32'd0);
    sendVsync(8);
    sendFrame(8'h00, 8'h00, 1'b1);
    sendVsync(8);
    checkOutput("postreset write count", 32'(wrA.size() - mW), 32'd12);
    for (int k = 0; k < 12; k++)
      checkWrite(1'b0, mW + k, 8'(k), {8'(k / 4), 8'(k % 4)}, "postreset pixel");
    checkOutput("postreset frame_done", 32'(fdA - mF), 32'd1);
    checkOutput("postreset frame_cnt", 32'(fcntA), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
